// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle RV32I controller and its datapath.
//   Decoded instruction fields and status (op, funct3, funct7b5, Zero,
//   MemReady) flow from datapath to controller; all mux selects, enables,
//   ALU control and the retire/illegal pulses flow back.
//   master : controller side (drives the control outputs)
//   slave  : datapath side (drives instruction fields and status)
interface multicycle_controller_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic       MemReady;

  logic       PCWrite;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ALUControl;
  logic [1:0] ImmSrc;
  logic       RegWrite;
  logic       InstrDone;
  logic       Illegal;

  modport master (
    input  op, funct3, funct7b5, Zero, MemReady,
    output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           ALUControl, ImmSrc, RegWrite, InstrDone, Illegal
  );

  modport slave (
    output op, funct3, funct7b5, Zero, MemReady,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           ALUControl, ImmSrc, RegWrite, InstrDone, Illegal
  );
endinterface

// File: rtl/multicycle_controller.sv
// Control FSM for the multicycle RV32I core (shared memory port, single ALU).
// Sequences the datapath one state per cycle, stalls on MemReady in FETCH,
// MEMREAD and MEMWRITE, and pulses InstrDone once per retired instruction.
//   clk   : rising-edge clock
//   reset : asynchronous active-high, returns the FSM to FETCH
//   bus   : controller side of multicycle_controller_if
// Only the state register is sequential; every output is combinational from
// the state and the current bus inputs.
module multicycle_controller (
  input  logic                     clk,
  input  logic                     reset,
  multicycle_controller_if.master  bus
);

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECR, EXECI, JAL, ALUWB, BEQ
  } state_t;

  state_t     state, nxt;
  logic [1:0] aluop;

  logic       pcwrite, adrsrc, memwrite, irwrite, regwrite, done, illegal;
  logic [1:0] resultsrc, srca, srcb, immsrc;
  logic [2:0] aluctl;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= FETCH;
    else       state <= nxt;
  end

  // Next state and per-state controls
  always_comb begin
    nxt       = state;
    aluop     = 2'b00;
    pcwrite   = 1'b0;
    adrsrc    = 1'b0;
    memwrite  = 1'b0;
    irwrite   = 1'b0;
    regwrite  = 1'b0;
    done      = 1'b0;
    illegal   = 1'b0;
    resultsrc = 2'b00;
    srca      = 2'b00;
    srcb      = 2'b00;
    case (state)
      FETCH: begin
        srcb      = 2'b10;
        resultsrc = 2'b10;
        if (bus.MemReady) begin
          irwrite = 1'b1;
          pcwrite = 1'b1;
          nxt     = DECODE;
        end
      end
      DECODE: begin
        // ALU forms OldPC+imm here so the branch target sits in ALUOut
        srca = 2'b01;
        srcb = 2'b01;
        case (bus.op)
          OP_LW, OP_SW: nxt = MEMADR;
          OP_R:         nxt = EXECR;
          OP_I:         nxt = EXECI;
          OP_JAL:       nxt = JAL;
          OP_BEQ:       nxt = BEQ;
          default: begin
            // PC already advanced in FETCH, so skipping is just a retire
            illegal = 1'b1;
            done    = 1'b1;
            nxt     = FETCH;
          end
        endcase
      end
      MEMADR: begin
        srca = 2'b10;
        srcb = 2'b01;
        nxt  = bus.op[5] ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        adrsrc = 1'b1;
        if (bus.MemReady) nxt = MEMWB;
      end
      MEMWB: begin
        resultsrc = 2'b01;
        regwrite  = 1'b1;
        done      = 1'b1;
        nxt       = FETCH;
      end
      MEMWRITE: begin
        adrsrc   = 1'b1;
        memwrite = 1'b1;
        if (bus.MemReady) begin
          done = 1'b1;
          nxt  = FETCH;
        end
      end
      EXECR: begin
        srca  = 2'b10;
        aluop = 2'b10;
        nxt   = ALUWB;
      end
      EXECI: begin
        srca  = 2'b10;
        srcb  = 2'b01;
        aluop = 2'b10;
        nxt   = ALUWB;
      end
      JAL: begin
        // PC <= branch target from ALUOut; ALU computes OldPC+4 for rd
        srca    = 2'b01;
        srcb    = 2'b10;
        pcwrite = 1'b1;
        nxt     = ALUWB;
      end
      ALUWB: begin
        regwrite = 1'b1;
        done     = 1'b1;
        nxt      = FETCH;
      end
      BEQ: begin
        srca    = 2'b10;
        aluop   = 2'b01;
        pcwrite = bus.Zero;
        done    = 1'b1;
        nxt     = FETCH;
      end
      default: nxt = FETCH;
    endcase
  end

  // ALU decoder
  always_comb begin
    aluctl = 3'b000;
    case (aluop)
      2'b00: aluctl = 3'b000;
      2'b01: aluctl = 3'b001;
      default: begin
        case (bus.funct3)
          // funct7b5 only selects sub for R-type; addi ignores it
          3'b000:  aluctl = (bus.op[5] & bus.funct7b5) ? 3'b001 : 3'b000;
          3'b010:  aluctl = 3'b101;
          3'b110:  aluctl = 3'b011;
          3'b111:  aluctl = 3'b010;
          default: aluctl = 3'b000;
        endcase
      end
    endcase
  end

  // Immediate format is purely a function of opcode
  always_comb begin
    case (bus.op)
      OP_SW:   immsrc = 2'b01;
      OP_BEQ:  immsrc = 2'b10;
      OP_JAL:  immsrc = 2'b11;
      default: immsrc = 2'b00;
    endcase
  end

  // Enables are gated by reset directly so an in-flight write drops the
  // moment reset rises, not at the next edge.
  assign bus.PCWrite    = pcwrite  & ~reset;
  assign bus.IRWrite    = irwrite  & ~reset;
  assign bus.MemWrite   = memwrite & ~reset;
  assign bus.RegWrite   = regwrite & ~reset;
  assign bus.InstrDone  = done     & ~reset;
  assign bus.Illegal    = illegal  & ~reset;
  assign bus.AdrSrc     = adrsrc;
  assign bus.ResultSrc  = resultsrc;
  assign bus.ALUSrcA    = srca;
  assign bus.ALUSrcB    = srcb;
  assign bus.ALUControl = aluctl;
  assign bus.ImmSrc     = immsrc;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller. Each step drives inputs just
// after a rising edge, pushes the expected control vector, and the vector is
// popped and compared on the following falling edge.
// Vector layout: {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA,
//                 ALUSrcB, ALUControl, ImmSrc, RegWrite, InstrDone, Illegal}
module tb_multicycle_controller;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BAD = 7'b1110011;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;
  logic [17:0] sbq[$];

  multicycle_controller_if bus ();

  multicycle_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  wire [17:0] obs = {bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite,
                     bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ALUControl,
                     bus.ImmSrc, bus.RegWrite, bus.InstrDone, bus.Illegal};

  function automatic logic [17:0] ev(
    input logic pcw, input logic adr, input logic mw, input logic irw,
    input logic [1:0] rs, input logic [1:0] sa, input logic [1:0] sb,
    input logic [2:0] alu, input logic [1:0] imm,
    input logic rw, input logic dn, input logic ill);
    return {pcw, adr, mw, irw, rs, sa, sb, alu, imm, rw, dn, ill};
  endfunction

  function automatic logic [17:0] fetch(input logic go, input logic [1:0] imm);
    return ev(go, 1'b0, 1'b0, go, 2'b10, 2'b00, 2'b10, 3'b000, imm, 1'b0, 1'b0, 1'b0);
  endfunction

  function automatic logic [17:0] dec(input logic [1:0] imm);
    return ev(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 3'b000, imm, 1'b0, 1'b0, 1'b0);
  endfunction

  function automatic logic [17:0] wb(input logic [1:0] imm, input logic [1:0] rs);
    return ev(1'b0, 1'b0, 1'b0, 1'b0, rs, 2'b00, 2'b00, 3'b000, imm, 1'b1, 1'b1, 1'b0);
  endfunction

  task automatic chk(input string tag);
    logic [17:0] exp;
    exp = sbq.pop_front();
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic setop(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    bus.op = o;
    bus.funct3 = f3;
    bus.funct7b5 = f7;
  endtask

  task automatic cyc(input logic rst, input logic mr, input logic z,
                     input logic [17:0] exp, input string tag);
    reset = rst;
    bus.MemReady = mr;
    bus.Zero = z;
    sbq.push_back(exp);
    @(negedge clk);
    chk(tag);
    @(posedge clk);
    #1;
  endtask

  typedef struct packed {
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    logic [1:0] sb;
    logic [2:0] alu;
  } alu_case_t;

  alu_case_t tbl [6];

  initial begin
    tbl = '{
      '{OP_R, 3'b111, 1'b0, 2'b00, 3'b010},
      '{OP_R, 3'b110, 1'b0, 2'b00, 3'b011},
      '{OP_R, 3'b100, 1'b0, 2'b00, 3'b000},
      '{OP_R, 3'b010, 1'b1, 2'b00, 3'b101},
      '{OP_I, 3'b010, 1'b0, 2'b01, 3'b101},
      '{OP_I, 3'b000, 1'b1, 2'b01, 3'b000}
    };

    setop(OP_R, 3'b000, 1'b1);
    bus.Zero = 1'b0;
    bus.MemReady = 1'b1;

    // Reset held with MemReady high: enables stay low, FETCH selects shown
    cyc(1'b1, 1'b1, 1'b0, fetch(1'b0, 2'b00), "rst_hold0");
    cyc(1'b1, 1'b1, 1'b0, fetch(1'b0, 2'b00), "rst_hold1");

    // R-type sub
    cyc(1'b0, 1'b1, 1'b0, fetch(1'b1, 2'b00), "sub_fetch");
    cyc(1'b0, 1'b1, 1'b0, dec(2'b00), "sub_decode");
    cyc(1'b0, 1'b1, 1'b0, ev(0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 2'b00, 0, 0, 0), "sub_execr");
    cyc(1'b0, 1'b1, 1'b0, wb(2'b00, 2'b00), "sub_aluwb");

    // ALU decode across R/I funct3 values
    foreach (tbl[k]) begin
      setop(tbl[k].op, tbl[k].f3, tbl[k].f7);
      cyc(1'b0, 1'b1, 1'b0, fetch(1'b1, 2'b00), $sformatf("alu%0d_fetch", k));
      cyc(1'b0, 1'b1, 1'b0, dec(2'b00), $sformatf("alu%0d_decode", k));
      cyc(1'b0, 1'b1, 1'b0, ev(0, 0, 0, 0, 2'b00, 2'b10, tbl[k].sb, tbl[k].alu, 2'b00, 0, 0, 0),
          $sformatf("alu%0d_exec", k));
      cyc(1'b0, 1'b1, 1'b0, wb(2'b00, 2'b00), $sformatf("alu%0d_aluwb", k));
    end

    // lw with two FETCH stalls and one MEMREAD stall: 8 cycles
    setop(OP_LW, 3'b010, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, fetch(1'b0, 2'b00), "lw_fetch_stall1");
    cyc(1'b0, 1'b0, 1'b0, fetch(1'b0, 2'b00), "lw_fetch_stall2");
    cyc(1'b0, 1'b1, 1'b0, fetch(1'b1, 2'b00), "lw_fetch_go");
    cyc(1'b0, 1'b1, 1'b0, dec(2'b00), "lw_decode");
    cyc(1'b0, 1'b1, 1'b0, ev(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 2'b00, 0, 0, 0), "lw_memadr");
    cyc(1'b0, 1'b0, 1'b0, ev(0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 0, 0, 0), "lw_memread_stall");
    cyc(1'b0, 1'b1, 1'b0, ev(0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 0, 0, 0), "lw_memread_go");
    cyc(1'b0, 1'b1, 1'b0, wb(2'b00, 2'b01), "lw_memwb");

    // beq taken and not taken
    for (int z = 1; z >= 0; z--) begin
      setop(OP_BEQ, 3'b000, 1'b0);
      cyc(1'b0, 1'b1, 1'(z), fetch(1'b1, 2'b10), $sformatf("beq_z%0d_fetch", z));
      cyc(1'b0, 1'b1, 1'(z), dec(2'b10), $sformatf("beq_z%0d_decode", z));
      cyc(1'b0, 1'b1, 1'(z), ev(1'(z), 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 2'b10, 0, 1, 0),
          $sformatf("beq_z%0d_beq", z));
    end

    // jal
    setop(OP_JAL, 3'b000, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, fetch(1'b1, 2'b11), "jal_fetch");
    cyc(1'b0, 1'b1, 1'b0, dec(2'b11), "jal_decode");
    cyc(1'b0, 1'b1, 1'b0, ev(1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'b000, 2'b11, 0, 0, 0), "jal_jal");
    cyc(1'b0, 1'b1, 1'b0, wb(2'b11, 2'b00), "jal_aluwb");

    // unsupported opcode: retired from DECODE, next cycle is a plain FETCH
    setop(OP_BAD, 3'b000, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, fetch(1'b1, 2'b00), "ill_fetch");
    cyc(1'b0, 1'b1, 1'b0, ev(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 2'b00, 0, 1, 1), "ill_decode");
    cyc(1'b0, 1'b0, 1'b0, fetch(1'b0, 2'b00), "ill_next_fetch");

    // sw stalled in MEMWRITE, reset raised mid-way through the 2nd cycle
    setop(OP_SW, 3'b010, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, fetch(1'b1, 2'b01), "sw_fetch");
    cyc(1'b0, 1'b1, 1'b0, dec(2'b01), "sw_decode");
    cyc(1'b0, 1'b1, 1'b0, ev(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 2'b01, 0, 0, 0), "sw_memadr");
    cyc(1'b0, 1'b0, 1'b0, ev(0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b01, 0, 0, 0), "sw_memwrite1");
    bus.MemReady = 1'b0;
    sbq.push_back(ev(0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b01, 0, 0, 0));
    @(negedge clk);
    chk("sw_memwrite2");
    reset = 1'b1;
    sbq.push_back(fetch(1'b0, 2'b01));
    #1;
    chk("sw_async_reset");
    @(posedge clk);
    #1;
    cyc(1'b1, 1'b1, 1'b0, fetch(1'b0, 2'b01), "sw_reset_hold");

    // next instruction fetches normally (addi with funct7b5 set still adds)
    setop(OP_I, 3'b000, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, fetch(1'b1, 2'b00), "post_fetch");
    cyc(1'b0, 1'b1, 1'b0, dec(2'b00), "post_decode");
    cyc(1'b0, 1'b1, 1'b0, ev(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 2'b00, 0, 0, 0), "post_execi");
    cyc(1'b0, 1'b1, 1'b0, wb(2'b00, 2'b00), "post_aluwb");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
